// File: rtl/byte_fetch_unit.sv
// byte_fetch_unit: instruction-side front end that assembles a 32-bit
// little-endian instruction from four byte reads of a shared RAM port,
// with a one-word buffer for repeated fetches of the same address.
module byte_fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              flush_i,
  input  logic              inval_i,
  input  logic              grant_i,
  input  logic [7:0]        mem_din,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic              mem_rd_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] inst_o
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;
  logic              buf_valid;
  logic              pending;
  logic [2:0]        iss;
  logic [2:0]        rcv;
  logic [7:0]        byte_q [3];
  logic              issue;

  // Issue decision and RAM port drive; the grant is only valid this cycle,
  // so address and read strobe follow it combinationally.
  always_comb begin
    issue    = (state == FETCH) && grant_i && (iss < 3'd4) && !flush_i;
    mem_a_o  = issue ? (base + ADDR_W'(iss)) : '0;
    mem_rd_o = issue && rdy;
    busy_o   = (state != IDLE);
    // A flush in the DONE cycle cancels the completion pulse.
    done_o   = (state == DONE) && !(flush_i && rdy);
  end

  // Fetch sequencing: issue counter, in-flight capture, assembly and buffer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      base      <= '0;
      buf_addr  <= '0;
      buf_data  <= '0;
      buf_valid <= 1'b0;
      pending   <= 1'b0;
      iss       <= '0;
      rcv       <= '0;
      inst_o    <= '0;
      for (int unsigned i = 0; i < 3; i++) byte_q[i] <= '0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          if (req_i && !flush_i) begin
            if (buf_valid && (buf_addr == addr_i)) begin
              inst_o <= buf_data;
              state  <= DONE;
            end else begin
              base    <= addr_i;
              iss     <= '0;
              rcv     <= '0;
              pending <= 1'b0;
              state   <= FETCH;
            end
          end
        end
        FETCH: begin
          if (flush_i) begin
            pending <= 1'b0;
            state   <= IDLE;
          end else begin
            pending <= issue;
            if (issue) iss <= iss + 3'd1;
            if (pending) begin
              rcv <= rcv + 3'd1;
              if (rcv == 3'd3) begin
                inst_o    <= {mem_din, byte_q[2], byte_q[1], byte_q[0]};
                buf_data  <= {mem_din, byte_q[2], byte_q[1], byte_q[0]};
                buf_addr  <= base;
                buf_valid <= 1'b1;
                state     <= DONE;
              end else begin
                byte_q[rcv[1:0]] <= mem_din;
              end
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // Placed last so an invalidate coinciding with completion wins over the load.
      if (inval_i) buf_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_byte_fetch_unit.sv
// tb_byte_fetch_unit: directed bench for byte_fetch_unit with a registered
// byte-wide RAM model that freezes when rdy is low.
module tb_byte_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, rdy, req_i, flush_i, inval_i, grant_i;
  logic [31:0] addr_i;
  logic [7:0]  mem_din = 8'h00;
  logic [31:0] mem_a_o;
  logic        mem_rd_o, busy_o, done_o;
  logic [31:0] inst_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] aq [$];
  int          acq [$];
  int          dq [$];
  logic [31:0] dinst;

  byte_fetch_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .req_i(req_i), .addr_i(addr_i),
    .flush_i(flush_i), .inval_i(inval_i), .grant_i(grant_i), .mem_din(mem_din),
    .mem_a_o(mem_a_o), .mem_rd_o(mem_rd_o), .busy_o(busy_o), .done_o(done_o),
    .inst_o(inst_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 8'h13;
      32'h0000_0101: return 8'h01;
      32'h0000_0102: return 8'h41;
      32'h0000_0103: return 8'h00;
      32'h0000_0200: return 8'h37;
      32'h0000_0201: return 8'h05;
      32'h0000_0202: return 8'h00;
      32'h0000_0203: return 8'h80;
      32'hFFFF_FFFE: return 8'hAA;
      32'hFFFF_FFFF: return 8'hBB;
      32'h0000_0000: return 8'hCC;
      32'h0000_0001: return 8'hDD;
      default:       return 8'hEE;
    endcase
  endfunction

  // One-cycle read latency; RAM frozen while rdy is low.
  always @(posedge clk) if (rdy) mem_din <= ram(mem_a_o);

  // Issues one request (sampled at edge "cycle 0") and records reads and
  // completions over cycles 1..ncyc. Starts and ends just after a posedge.
  task automatic run_req(input logic [31:0] a, input int gnt_off, input int rdy_off,
                         input int flush_cyc, input int inval_cyc, input int ncyc);
    aq.delete(); acq.delete(); dq.delete(); dinst = 'x;
    req_i = 1'b1; addr_i = a;
    @(posedge clk); #1;
    req_i = 1'b0;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      grant_i = (cyc != gnt_off);
      rdy     = (cyc != rdy_off);
      flush_i = (cyc == flush_cyc);
      inval_i = (cyc == inval_cyc);
      @(negedge clk);
      if (mem_rd_o) begin aq.push_back(mem_a_o); acq.push_back(cyc); end
      if (done_o) begin dq.push_back(cyc); dinst = inst_o; end
      @(posedge clk); #1;
    end
    grant_i = 1'b1; rdy = 1'b1; flush_i = 1'b0; inval_i = 1'b0;
  endtask

  task automatic pulse_inval();
    inval_i = 1'b1;
    @(posedge clk); #1;
    inval_i = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
      n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done_o); end
      n_checks++; if (mem_rd_o !== 1'b0) begin n_fail++; $display("FAIL reset_rd got=%b exp=0", mem_rd_o); end
      n_checks++; if (mem_a_o !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", mem_a_o); end
      n_checks++; if (inst_o !== 32'h0) begin n_fail++; $display("FAIL reset_inst got=%h exp=0", inst_o); end
    end
    @(posedge clk); #1;
    rst = 1'b1; req_i = 1'b0;
  endtask

  task automatic test_miss();
    logic [31:0] ea [4];
    int          ec [4];
    ea = '{32'h100, 32'h101, 32'h102, 32'h103};
    ec = '{1, 2, 3, 4};
    run_req(32'h100, 0, 0, 0, 0, 10);
    n_checks++; if (aq.size() != 4) begin n_fail++; $display("FAIL miss_nreads got=%0d exp=4", aq.size()); end
    for (int i = 0; i < 4 && i < aq.size(); i++) begin
      n_checks++; if (aq[i] !== ea[i] || acq[i] != ec[i]) begin
        n_fail++; $display("FAIL miss_read%0d got=%h@%0d exp=%h@%0d", i, aq[i], acq[i], ea[i], ec[i]);
      end
    end
    n_checks++; if (dq.size() != 1 || dq[0] != 6) begin n_fail++; $display("FAIL miss_done_cycle got=%p exp=6", dq); end
    n_checks++; if (dinst !== 32'h0041_0113) begin n_fail++; $display("FAIL miss_inst got=%h exp=00410113", dinst); end
    @(negedge clk);
    n_checks++; if (inst_o !== 32'h0041_0113) begin n_fail++; $display("FAIL miss_inst_hold got=%h exp=00410113", inst_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_hit();
    run_req(32'h100, 0, 0, 0, 0, 4);
    n_checks++; if (aq.size() != 0) begin n_fail++; $display("FAIL hit_nreads got=%0d exp=0", aq.size()); end
    n_checks++; if (dq.size() != 1 || dq[0] != 1) begin n_fail++; $display("FAIL hit_done_cycle got=%p exp=1", dq); end
    n_checks++; if (dinst !== 32'h0041_0113) begin n_fail++; $display("FAIL hit_inst got=%h exp=00410113", dinst); end
  endtask

  task automatic test_inval();
    pulse_inval();
    run_req(32'h100, 0, 0, 0, 0, 10);
    n_checks++; if (aq.size() != 4) begin n_fail++; $display("FAIL inval_nreads got=%0d exp=4", aq.size()); end
    n_checks++; if (dq.size() != 1 || dq[0] != 6) begin n_fail++; $display("FAIL inval_done_cycle got=%p exp=6", dq); end
    n_checks++; if (dinst !== 32'h0041_0113) begin n_fail++; $display("FAIL inval_inst got=%h exp=00410113", dinst); end
  endtask

  task automatic test_gaps();
    logic [31:0] ea [4];
    int          ec [4];
    ea = '{32'h100, 32'h101, 32'h102, 32'h103};
    ec = '{1, 3, 5, 6};
    pulse_inval();
    run_req(32'h100, 2, 4, 0, 0, 12);
    n_checks++; if (aq.size() != 4) begin n_fail++; $display("FAIL gaps_nreads got=%0d exp=4", aq.size()); end
    for (int i = 0; i < 4 && i < aq.size(); i++) begin
      n_checks++; if (aq[i] !== ea[i] || acq[i] != ec[i]) begin
        n_fail++; $display("FAIL gaps_read%0d got=%h@%0d exp=%h@%0d", i, aq[i], acq[i], ea[i], ec[i]);
      end
    end
    n_checks++; if (dq.size() != 1 || dq[0] != 8) begin n_fail++; $display("FAIL gaps_done_cycle got=%p exp=8", dq); end
    n_checks++; if (dinst !== 32'h0041_0113) begin n_fail++; $display("FAIL gaps_inst got=%h exp=00410113", dinst); end
  endtask

  task automatic test_flush();
    logic [31:0] ea [4];
    ea = '{32'h200, 32'h201, 32'h202, 32'h203};
    pulse_inval();
    run_req(32'h100, 0, 0, 4, 0, 8);
    n_checks++; if (dq.size() != 0) begin n_fail++; $display("FAIL flush_no_done got=%0d exp=0", dq.size()); end
    @(negedge clk);
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_idle got=%b exp=0", busy_o); end
    @(posedge clk); #1;
    run_req(32'h200, 0, 0, 0, 0, 10);
    n_checks++; if (aq.size() != 4) begin n_fail++; $display("FAIL flush_nreads got=%0d exp=4", aq.size()); end
    for (int i = 0; i < 4 && i < aq.size(); i++) begin
      n_checks++; if (aq[i] !== ea[i] || acq[i] != i + 1) begin
        n_fail++; $display("FAIL flush_read%0d got=%h@%0d exp=%h@%0d", i, aq[i], acq[i], ea[i], i + 1);
      end
    end
    n_checks++; if (dq.size() != 1 || dq[0] != 6) begin n_fail++; $display("FAIL flush_done_cycle got=%p exp=6", dq); end
    n_checks++; if (dinst !== 32'h8000_0537) begin n_fail++; $display("FAIL flush_inst got=%h exp=80000537", dinst); end
  endtask

  task automatic test_wrap();
    logic [31:0] ea [4];
    ea = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    run_req(32'hFFFF_FFFE, 0, 0, 0, 0, 10);
    n_checks++; if (aq.size() != 4) begin n_fail++; $display("FAIL wrap_nreads got=%0d exp=4", aq.size()); end
    for (int i = 0; i < 4 && i < aq.size(); i++) begin
      n_checks++; if (aq[i] !== ea[i]) begin n_fail++; $display("FAIL wrap_read%0d got=%h exp=%h", i, aq[i], ea[i]); end
    end
    n_checks++; if (dinst !== 32'hDDCC_BBAA) begin n_fail++; $display("FAIL wrap_inst got=%h exp=ddccbbaa", dinst); end
  endtask

  task automatic test_inval_at_completion();
    run_req(32'h100, 0, 0, 0, 5, 10);
    n_checks++; if (dq.size() != 1 || dq[0] != 6) begin n_fail++; $display("FAIL invdone_done_cycle got=%p exp=6", dq); end
    n_checks++; if (dinst !== 32'h0041_0113) begin n_fail++; $display("FAIL invdone_inst got=%h exp=00410113", dinst); end
    run_req(32'h100, 0, 0, 0, 0, 10);
    n_checks++; if (aq.size() != 4) begin n_fail++; $display("FAIL invdone_refetch got=%0d exp=4", aq.size()); end
  endtask

  task automatic test_flush_idle();
    // 0x100 is buffered here, so an unflushed request would hit.
    req_i = 1'b1; flush_i = 1'b1; addr_i = 32'h100;
    @(posedge clk); #1;
    req_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL flushidle_done got=%b exp=0", done_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL flushidle_busy got=%b exp=0", busy_o); end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; req_i = 1'b1; addr_i = 32'h100;
    flush_i = 1'b0; inval_i = 1'b0; grant_i = 1'b1;
    test_reset();
    test_miss();
    test_hit();
    test_inval();
    test_gaps();
    test_flush();
    test_wrap();
    test_inval_at_completion();
    test_flush_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
